alt_vipvfr121_common_burst_sequencer: RTL and testbench
=======================================================

# alt_vipvfr121_common_burst_sequencer

Sequencer that drives the user-side command and data interface of the common Avalon-MM bursting master. A client requests one linear transfer of N words, either a write or a read. The block splits it into burst commands of at most BURST_LENGTH words and issues them in order. It paces client data beats against commands that have already been accepted, so the master's global stall can never deadlock command issue. It then reports completion.

## Interface
- ADDR_WIDTH, 16, byte-address width (matches the master)
- DATA_WIDTH, 16, data word width
- MAX_BURST_LENGTH_REQUIREDWIDTH, 11, width of master_burst_length
- LEN_WIDTH, 24, width of the transfer word count
- BURST_LENGTH, 32, maximum words per command; must be ≥1 and fit in MAX_BURST_LENGTH_REQUIREDWIDTH
- WORD_BYTES, 2, address increment per word
- OUTSTANDING_MAX, 64, cap on commanded-but-untransferred words; must be ≥ BURST_LENGTH
- clock  in  1  single clock for all logic
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle transfer request; ignored while busy
- start_addr  in  ADDR_WIDTH  first byte address
- start_words  in  LEN_WIDTH  transfer length in words
- start_write  in  1  1 = write, 0 = read
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- client_wdata  in  DATA_WIDTH  write data
- client_wvalid  in  1  write data valid
- client_wready  out  1  write beat accepted when wvalid && wready
- client_rdata  out  DATA_WIDTH  read data
- client_rvalid  out  1  read data valid
- client_rready  in  1  read beat consumed when rvalid && rready
- master_addr  out  ADDR_WIDTH  command address
- master_command  out  1  command enable
- master_is_burst  out  1  high when command length > 1
- master_is_write_not_read  out  1  command direction
- master_burst_length  out  MAX_BURST_LENGTH_REQUIREDWIDTH  command length in words
- master_writedata  out  DATA_WIDTH  write data
- master_write  out  1  write enable
- master_readdata  in  DATA_WIDTH  show-ahead read data; valid in any cycle where master_read && !master_stall
- master_read  out  1  read enable
- master_stall  in  1  global stall; while high, the master ignores command, write and read

## Operation
- FSM states: IDLE, RUN, FINISH.
- **IDLE**
  - start latches addr, words remaining, direction, and sets transferred = 0.
  - start_words = 0 goes to FINISH; otherwise goes to RUN.
- **RUN, command side**
  - cmd_len = min(BURST_LENGTH, cmd_words_left).
  - master_command = 1 while cmd_words_left > 0 && (credit + cmd_len) ≤ OUTSTANDING_MAX.
  - A command is accepted when master_command && !master_stall. On acceptance: addr += cmd_len*WORD_BYTES (wraps mod 2^ADDR_WIDTH), cmd_words_left −= cmd_len, credit += cmd_len.
  - Command outputs are registered and stay stable until accepted.
- **RUN, write data side** (data is passed through combinationally)
  - master_write = client_wvalid && credit > 0.
  - client_wready = credit > 0 && !master_stall.
  - master_writedata = client_wdata.
  - Each beat: credit −= 1, transferred += 1.
- **RUN, read data side** (data is passed through combinationally)
  - master_read = client_rready && credit > 0.
  - client_rvalid = credit > 0 && !master_stall.
  - client_rdata = master_readdata.
  - Each beat: credit −= 1, transferred += 1.
- Data beats are never requested beyond credit. A stall caused by an empty read FIFO therefore always has a command already issued behind it.
- A command acceptance and a data beat in the same cycle: credit changes by cmd_len − 1.
- transferred == start_words goes to FINISH.
- **FINISH**: done = 1 for one cycle, then IDLE.
- busy = 1 in RUN and FINISH.
- start while busy is ignored; no latched values change.

## Timing
- Reset values: every output 0; internal counters 0; state IDLE.
- start at cycle t:
  - busy = 1 from t+1.
  - First master_command at t+1 with master_addr = start_addr.
- With stall low and credit available, commands issue back-to-back, one per cycle.
- Data throughput is one beat per cycle when unstalled.
- done is asserted the cycle after the final data beat. busy drops in the cycle after done.
- For start_words = 0: done and busy are both high at t+1 only, and no command is issued.
- Reset mid-transfer returns to IDLE next cycle with all outputs low. Master FIFOs are not flushed; the master must be reset alongside this block.

## Test plan
- **Write, multi-burst**: write 70 words, addr 0x100, BURST_LENGTH 32, stall low -> commands (0x100,32), (0x140,32), (0x180,6) with is_write_not_read = 1; 70 beats in order; done one cycle after the 70th beat.
- **Read, single burst**: read 5 words, rready high, readdata 1..5 -> one command of length 5 with is_burst = 1; client_rvalid beats 1..5; done pulse; busy low afterwards.
- **Stall on a command**: stall held 3 cycles while the second command is pending -> addr and length unchanged, no duplicate command, correct addresses after release.
- **Credit cap**: read 128 words, OUTSTANDING_MAX 64, rready low -> exactly 2 commands issued, master_read stays 0, no third command until beats drain.
- **Edge starts**: start_words = 0 -> done at t+1 and no command. start pulsed while busy -> ignored, transfer unaffected.
- **Reset mid-transfer**: reset after 10 write beats -> next cycle all outputs 0 and busy 0; a new 4-word write then completes normally.

Source files
------------

// File: rtl/alt_vipvfr121_common_burst_sequencer_if.sv
// Client request, client data and bursting-master command/data signals of the burst sequencer.
// The sequencer uses the master modport; the surrounding client/master logic uses the slave modport.
interface alt_vipvfr121_common_burst_sequencer_if #(
   parameter int ADDR_WIDTH                     = 16,
   parameter int DATA_WIDTH                     = 16,
   parameter int MAX_BURST_LENGTH_REQUIREDWIDTH = 11,
   parameter int LEN_WIDTH                      = 24
);
   logic                                      start;
   logic [ADDR_WIDTH-1:0]                     start_addr;
   logic [LEN_WIDTH-1:0]                      start_words;
   logic                                      start_write;
   logic                                      busy;
   logic                                      done;
   logic [DATA_WIDTH-1:0]                     client_wdata;
   logic                                      client_wvalid;
   logic                                      client_wready;
   logic [DATA_WIDTH-1:0]                     client_rdata;
   logic                                      client_rvalid;
   logic                                      client_rready;
   logic [ADDR_WIDTH-1:0]                     master_addr;
   logic                                      master_command;
   logic                                      master_is_burst;
   logic                                      master_is_write_not_read;
   logic [MAX_BURST_LENGTH_REQUIREDWIDTH-1:0] master_burst_length;
   logic [DATA_WIDTH-1:0]                     master_writedata;
   logic                                      master_write;
   logic [DATA_WIDTH-1:0]                     master_readdata;
   logic                                      master_read;
   logic                                      master_stall;

   modport master (
      input  start, start_addr, start_words, start_write,
      input  client_wdata, client_wvalid, client_rready,
      input  master_readdata, master_stall,
      output busy, done, client_wready, client_rdata, client_rvalid,
      output master_addr, master_command, master_is_burst, master_is_write_not_read,
      output master_burst_length, master_writedata, master_write, master_read
   );

   modport slave (
      output start, start_addr, start_words, start_write,
      output client_wdata, client_wvalid, client_rready,
      output master_readdata, master_stall,
      input  busy, done, client_wready, client_rdata, client_rvalid,
      input  master_addr, master_command, master_is_burst, master_is_write_not_read,
      input  master_burst_length, master_writedata, master_write, master_read
   );
endinterface

// File: rtl/alt_vipvfr121_common_burst_sequencer.sv
// Splits one linear client transfer into bursts for the bursting master, pacing client
// data beats against the credit of words already commanded so the global stall cannot deadlock.
module alt_vipvfr121_common_burst_sequencer #(
   parameter int ADDR_WIDTH                     = 16,
   parameter int DATA_WIDTH                     = 16,
   parameter int MAX_BURST_LENGTH_REQUIREDWIDTH = 11,
   parameter int LEN_WIDTH                      = 24,
   parameter int BURST_LENGTH                   = 32,
   parameter int WORD_BYTES                     = 2,
   parameter int OUTSTANDING_MAX                = 64
) (
   input logic clock,
   input logic reset,
   alt_vipvfr121_common_burst_sequencer_if.master bus
);
   localparam int CRW = $clog2(OUTSTANDING_MAX + 1);
   localparam int LW1 = LEN_WIDTH + 1;
   localparam logic [LEN_WIDTH-1:0]  BURST_L      = LEN_WIDTH'(BURST_LENGTH);
   localparam logic [LEN_WIDTH:0]    OUT_MAX_L    = LW1'(OUTSTANDING_MAX);
   localparam logic [ADDR_WIDTH-1:0] WORD_BYTES_A = ADDR_WIDTH'(WORD_BYTES);

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   state_t                state, state_next;
   logic [ADDR_WIDTH-1:0] addr;
   logic [LEN_WIDTH-1:0]  cmd_left;
   logic [LEN_WIDTH-1:0]  words;
   logic [LEN_WIDTH-1:0]  transferred;
   logic [CRW-1:0]        credit;
   logic                  is_write;
   logic [LEN_WIDTH-1:0]  cmd_len;
   logic                  run, has_credit, cmd_ok, cmd_accept, wr_beat, rd_beat, beat;
   logic                  busy_c, done_c;

   function automatic logic [LEN_WIDTH-1:0] min_len(input logic [LEN_WIDTH-1:0] left);
      return (left > BURST_L) ? BURST_L : left;
   endfunction

   assign cmd_len    = min_len(cmd_left);
   assign run        = (state == RUN);
   assign has_credit = (credit != '0);
   // A command only goes out if its words still fit under the outstanding cap.
   assign cmd_ok     = run && (cmd_left != '0) &&
                       (({1'b0, cmd_len} + LW1'(credit)) <= OUT_MAX_L);
   assign cmd_accept = cmd_ok && !bus.master_stall;
   assign wr_beat    = run && is_write && has_credit && !bus.master_stall && bus.client_wvalid;
   assign rd_beat    = run && !is_write && has_credit && !bus.master_stall && bus.client_rready;
   assign beat       = wr_beat || rd_beat;

   assign bus.master_command           = cmd_ok;
   assign bus.master_addr              = addr;
   assign bus.master_burst_length      = MAX_BURST_LENGTH_REQUIREDWIDTH'(cmd_len);
   assign bus.master_is_burst          = (cmd_len > LEN_WIDTH'(1));
   assign bus.master_is_write_not_read = is_write;
   assign bus.master_write             = run && is_write && has_credit && bus.client_wvalid;
   assign bus.client_wready            = run && is_write && has_credit && !bus.master_stall;
   assign bus.master_writedata         = (run && is_write) ? bus.client_wdata : '0;
   assign bus.master_read              = run && !is_write && has_credit && bus.client_rready;
   assign bus.client_rvalid            = run && !is_write && has_credit && !bus.master_stall;
   assign bus.client_rdata             = (run && !is_write) ? bus.master_readdata : '0;
   assign bus.busy                     = busy_c;
   assign bus.done                     = done_c;

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      busy_c     = 1'b0;
      done_c     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) state_next = (bus.start_words == '0) ? FINISH : RUN;
         end
         RUN: begin
            busy_c = 1'b1;
            if (beat && ((transferred + LEN_WIDTH'(1)) == words)) state_next = FINISH;
         end
         FINISH: begin
            busy_c     = 1'b1;
            done_c     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         addr        <= '0;
         cmd_left    <= '0;
         words       <= '0;
         transferred <= '0;
         credit      <= '0;
         is_write    <= 1'b0;
      end else if (state == IDLE) begin
         if (bus.start) begin
            addr        <= bus.start_addr;
            cmd_left    <= bus.start_words;
            words       <= bus.start_words;
            transferred <= '0;
            credit      <= '0;
            is_write    <= bus.start_write;
         end
      end else if (run) begin
         if (cmd_accept) begin
            addr     <= addr + ADDR_WIDTH'(cmd_len) * WORD_BYTES_A;
            cmd_left <= cmd_left - cmd_len;
         end
         // Command acceptance and data beat in one cycle net to cmd_len - 1.
         credit <= credit + (cmd_accept ? CRW'(cmd_len) : CRW'(0)) - (beat ? CRW'(1) : CRW'(0));
         if (beat) transferred <= transferred + LEN_WIDTH'(1);
      end
   end
endmodule

// File: tb/tb_alt_vipvfr121_common_burst_sequencer.sv
// Scoreboard bench for the burst sequencer: expected commands and data words are queued
// at stimulus time and compared as the DUT accepts commands and moves data beats.
module tb_alt_vipvfr121_common_burst_sequencer;
   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   alt_vipvfr121_common_burst_sequencer_if bus ();

   alt_vipvfr121_common_burst_sequencer dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.master)
   );

   typedef struct {
      logic [15:0] addr;
      logic [10:0] len;
      logic        wr;
   } cmd_t;

   cmd_t        exp_cmd[$];
   logic [15:0] exp_data[$];
   cmd_t        ec;
   logic [15:0] ed;
   int          n_cmp = 0, n_err = 0, cyc_n = 0, s_cyc = 0;
   logic        s_cmd_raw, s_cmd, s_burst, s_wr, s_wbeat, s_rbeat, s_mread, s_mwrite;
   logic        s_wready, s_rvalid, s_done, s_busy;
   logic [15:0] s_addr, s_wdata, s_rdata;
   logic [10:0] s_len;

   // Sample on the falling edge, then step to just after the next rising edge.
   task automatic cyc();
      @(negedge clock);
      s_cmd_raw = bus.master_command;
      s_cmd     = bus.master_command && !bus.master_stall;
      s_addr    = bus.master_addr;
      s_len     = bus.master_burst_length;
      s_burst   = bus.master_is_burst;
      s_wr      = bus.master_is_write_not_read;
      s_wbeat   = bus.client_wvalid && bus.client_wready;
      s_rbeat   = bus.client_rvalid && bus.client_rready;
      s_mwrite  = bus.master_write;
      s_mread   = bus.master_read;
      s_wready  = bus.client_wready;
      s_rvalid  = bus.client_rvalid;
      s_wdata   = bus.master_writedata;
      s_rdata   = bus.client_rdata;
      s_done    = bus.done;
      s_busy    = bus.busy;
      s_cyc     = cyc_n;
      @(posedge clock);
      #1;
      cyc_n++;
   endtask

   task automatic do_start(input logic [15:0] a, input logic [23:0] w, input logic wr);
      bus.start       = 1'b1;
      bus.start_addr  = a;
      bus.start_words = w;
      bus.start_write = wr;
      cyc();
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
      n_cmp++;
      if ({s_busy, s_done, s_cmd_raw, s_mwrite, s_mread, s_wready, s_rvalid, s_burst, s_wr} !== 9'b0) begin
         n_err++;
         $display("FAIL reset_ctrl: got %b, required 000000000",
                  {s_busy, s_done, s_cmd_raw, s_mwrite, s_mread, s_wready, s_rvalid, s_burst, s_wr});
      end
      n_cmp++;
      if (s_addr !== 16'h0 || s_len !== 11'h0 || s_wdata !== 16'h0 || s_rdata !== 16'h0) begin
         n_err++;
         $display("FAIL reset_data: got addr %h len %0d wdata %h rdata %h, required all 0",
                  s_addr, s_len, s_wdata, s_rdata);
      end
   endtask

   task automatic test_write_multi();
      int beats = 0, last = -10;
      bit done_seen = 0;
      exp_cmd.delete(); exp_data.delete();
      exp_cmd.push_back('{16'h0100, 11'd32, 1'b1});
      exp_cmd.push_back('{16'h0140, 11'd32, 1'b1});
      exp_cmd.push_back('{16'h0180, 11'd6, 1'b1});
      for (int i = 0; i < 70; i++) exp_data.push_back(16'hA000 + 16'(i));
      bus.client_wvalid = 1'b1;
      bus.client_wdata  = 16'hA000;
      do_start(16'h0100, 24'd70, 1'b1);
      for (int k = 0; k < 300 && !done_seen; k++) begin
         cyc();
         if (k == 0) begin
            n_cmp++;
            if (s_busy !== 1'b1 || s_cmd_raw !== 1'b1 || s_addr !== 16'h0100) begin
               n_err++;
               $display("FAIL wr_first_cmd: got busy %b cmd %b addr %h, required 1 1 0100", s_busy, s_cmd_raw, s_addr);
            end
         end
         if (s_cmd) begin
            n_cmp++;
            if (exp_cmd.size() == 0) begin
               n_err++;
               $display("FAIL wr_cmd_extra: got addr %h len %0d, required no command", s_addr, s_len);
            end else begin
               ec = exp_cmd.pop_front();
               if (s_addr !== ec.addr || s_len !== ec.len || s_wr !== ec.wr || s_burst !== (ec.len > 11'd1)) begin
                  n_err++;
                  $display("FAIL wr_cmd: got %h/%0d/%b/%b, required %h/%0d/%b", s_addr, s_len, s_wr, s_burst, ec.addr, ec.len, ec.wr);
               end
            end
         end
         if (s_wbeat) begin
            n_cmp++;
            ed = (exp_data.size() != 0) ? exp_data.pop_front() : 16'hxxxx;
            if (s_wdata !== ed || s_mwrite !== 1'b1) begin
               n_err++;
               $display("FAIL wr_data: got %h write %b, required %h write 1", s_wdata, s_mwrite, ed);
            end
            beats++;
            last = s_cyc;
            bus.client_wdata = 16'hA000 + 16'(beats);
         end
         if (s_done) begin
            done_seen = 1;
            n_cmp++;
            if (s_cyc !== last + 1) begin
               n_err++;
               $display("FAIL wr_done_timing: got cycle %0d, required %0d", s_cyc, last + 1);
            end
         end
      end
      bus.client_wvalid = 1'b0;
      n_cmp++;
      if (!done_seen || beats !== 70 || exp_cmd.size() !== 0) begin
         n_err++;
         $display("FAIL wr_complete: got done %b beats %0d cmds_left %0d, required 1 70 0", done_seen, beats, exp_cmd.size());
      end
      cyc();
      n_cmp++;
      if (s_busy !== 1'b0) begin
         n_err++;
         $display("FAIL wr_busy_after: got %b, required 0", s_busy);
      end
   endtask

   task automatic test_read_single();
      int beats = 0;
      bit done_seen = 0;
      exp_cmd.delete(); exp_data.delete();
      exp_cmd.push_back('{16'h0200, 11'd5, 1'b0});
      for (int i = 1; i <= 5; i++) exp_data.push_back(16'(i));
      bus.client_rready   = 1'b1;
      bus.master_readdata = 16'd1;
      do_start(16'h0200, 24'd5, 1'b0);
      for (int k = 0; k < 50 && !done_seen; k++) begin
         cyc();
         if (s_cmd) begin
            n_cmp++;
            ec = (exp_cmd.size() != 0) ? exp_cmd.pop_front() : '{16'hxxxx, 11'hxxx, 1'bx};
            if (s_addr !== ec.addr || s_len !== ec.len || s_wr !== ec.wr || s_burst !== 1'b1) begin
               n_err++;
               $display("FAIL rd_cmd: got %h/%0d/%b/%b, required %h/%0d/%b/1", s_addr, s_len, s_wr, s_burst, ec.addr, ec.len, ec.wr);
            end
         end
         if (s_rbeat) begin
            n_cmp++;
            ed = (exp_data.size() != 0) ? exp_data.pop_front() : 16'hxxxx;
            if (s_rdata !== ed || s_mread !== 1'b1) begin
               n_err++;
               $display("FAIL rd_data: got %h read %b, required %h read 1", s_rdata, s_mread, ed);
            end
            beats++;
            bus.master_readdata = 16'(beats + 1);
         end
         if (s_done) done_seen = 1;
      end
      n_cmp++;
      if (!done_seen || beats !== 5 || exp_cmd.size() !== 0) begin
         n_err++;
         $display("FAIL rd_complete: got done %b beats %0d cmds_left %0d, required 1 5 0", done_seen, beats, exp_cmd.size());
      end
      cyc();
      n_cmp++;
      if (s_busy !== 1'b0 || s_rvalid !== 1'b0) begin
         n_err++;
         $display("FAIL rd_busy_after: got busy %b rvalid %b, required 0 0", s_busy, s_rvalid);
      end
      bus.client_rready = 1'b0;
   endtask

   task automatic test_stall_cmd();
      int beats = 0, ncmd = 0, stall_left = 0;
      bit done_seen = 0;
      exp_cmd.delete(); exp_data.delete();
      exp_cmd.push_back('{16'h0400, 11'd32, 1'b1});
      exp_cmd.push_back('{16'h0440, 11'd32, 1'b1});
      exp_cmd.push_back('{16'h0480, 11'd16, 1'b1});
      for (int i = 0; i < 80; i++) exp_data.push_back(16'h3000 + 16'(i));
      bus.client_wvalid = 1'b1;
      bus.client_wdata  = 16'h3000;
      do_start(16'h0400, 24'd80, 1'b1);
      for (int k = 0; k < 400 && !done_seen; k++) begin
         bus.master_stall = (stall_left > 0);
         cyc();
         if (stall_left > 0) begin
            stall_left--;
            n_cmp++;
            if (s_cmd_raw !== 1'b1 || s_addr !== 16'h0440 || s_len !== 11'd32 || s_wbeat !== 1'b0) begin
               n_err++;
               $display("FAIL stall_hold: got cmd %b addr %h len %0d beat %b, required 1 0440 32 0", s_cmd_raw, s_addr, s_len, s_wbeat);
            end
         end
         if (s_cmd) begin
            n_cmp++;
            ec = (exp_cmd.size() != 0) ? exp_cmd.pop_front() : '{16'hxxxx, 11'hxxx, 1'bx};
            if (s_addr !== ec.addr || s_len !== ec.len) begin
               n_err++;
               $display("FAIL stall_cmd: got %h/%0d, required %h/%0d", s_addr, s_len, ec.addr, ec.len);
            end
            ncmd++;
            if (ncmd == 1) stall_left = 3;
         end
         if (s_wbeat) begin
            n_cmp++;
            ed = (exp_data.size() != 0) ? exp_data.pop_front() : 16'hxxxx;
            if (s_wdata !== ed) begin
               n_err++;
               $display("FAIL stall_data: got %h, required %h", s_wdata, ed);
            end
            beats++;
            bus.client_wdata = 16'h3000 + 16'(beats);
         end
         if (s_done) done_seen = 1;
      end
      bus.master_stall  = 1'b0;
      bus.client_wvalid = 1'b0;
      n_cmp++;
      if (!done_seen || beats !== 80 || ncmd !== 3) begin
         n_err++;
         $display("FAIL stall_complete: got done %b beats %0d cmds %0d, required 1 80 3", done_seen, beats, ncmd);
      end
      cyc();
   endtask

   task automatic test_credit_cap();
      int beats = 0, ncmd = 0;
      bit done_seen = 0, mread_seen = 0;
      exp_cmd.delete(); exp_data.delete();
      for (int i = 0; i < 4; i++) exp_cmd.push_back('{16'h2000 + 16'(i * 64), 11'd32, 1'b0});
      for (int i = 0; i < 128; i++) exp_data.push_back(16'h5000 + 16'(i));
      bus.client_rready   = 1'b0;
      bus.master_readdata = 16'h5000;
      do_start(16'h2000, 24'd128, 1'b0);
      for (int k = 0; k < 600 && !done_seen; k++) begin
         if (k == 20) begin
            n_cmp++;
            if (ncmd !== 2 || mread_seen !== 1'b0) begin
               n_err++;
               $display("FAIL credit_cap: got cmds %0d read_seen %b, required 2 0", ncmd, mread_seen);
            end
            bus.client_rready = 1'b1;
         end
         cyc();
         if (s_mread) mread_seen = 1;
         if (s_cmd) begin
            n_cmp++;
            ec = (exp_cmd.size() != 0) ? exp_cmd.pop_front() : '{16'hxxxx, 11'hxxx, 1'bx};
            if (s_addr !== ec.addr || s_len !== ec.len || s_wr !== ec.wr || beats < 32 * (ncmd - 1)) begin
               n_err++;
               $display("FAIL credit_cmd: got %h/%0d/%b after %0d beats, required %h/%0d/%b after >=%0d",
                        s_addr, s_len, s_wr, beats, ec.addr, ec.len, ec.wr, 32 * (ncmd - 1));
            end
            ncmd++;
         end
         if (s_rbeat) begin
            n_cmp++;
            ed = (exp_data.size() != 0) ? exp_data.pop_front() : 16'hxxxx;
            if (s_rdata !== ed) begin
               n_err++;
               $display("FAIL credit_data: got %h, required %h", s_rdata, ed);
            end
            beats++;
            bus.master_readdata = 16'h5000 + 16'(beats);
         end
         if (s_done) done_seen = 1;
      end
      bus.client_rready = 1'b0;
      n_cmp++;
      if (!done_seen || beats !== 128 || ncmd !== 4) begin
         n_err++;
         $display("FAIL credit_complete: got done %b beats %0d cmds %0d, required 1 128 4", done_seen, beats, ncmd);
      end
      cyc();
   endtask

   task automatic test_edge_starts();
      int beats = 0;
      bit done_seen = 0;
      do_start(16'h0300, 24'd0, 1'b1);
      cyc();
      n_cmp++;
      if (s_done !== 1'b1 || s_busy !== 1'b1 || s_cmd_raw !== 1'b0) begin
         n_err++;
         $display("FAIL zero_words: got done %b busy %b cmd %b, required 1 1 0", s_done, s_busy, s_cmd_raw);
      end
      cyc();
      n_cmp++;
      if (s_done !== 1'b0 || s_busy !== 1'b0) begin
         n_err++;
         $display("FAIL zero_words_after: got done %b busy %b, required 0 0", s_done, s_busy);
      end
      exp_cmd.delete(); exp_data.delete();
      exp_cmd.push_back('{16'h0500, 11'd4, 1'b1});
      for (int i = 0; i < 4; i++) exp_data.push_back(16'hB000 + 16'(i));
      bus.client_wvalid = 1'b1;
      bus.client_wdata  = 16'hB000;
      do_start(16'h0500, 24'd4, 1'b1);
      for (int k = 0; k < 50 && !done_seen; k++) begin
         if (k == 1) begin
            bus.start       = 1'b1;
            bus.start_addr  = 16'h0700;
            bus.start_words = 24'd9;
            bus.start_write = 1'b0;
         end
         if (k == 2) bus.start = 1'b0;
         cyc();
         if (s_cmd) begin
            n_cmp++;
            ec = (exp_cmd.size() != 0) ? exp_cmd.pop_front() : '{16'hxxxx, 11'hxxx, 1'bx};
            if (s_addr !== ec.addr || s_len !== ec.len || s_wr !== ec.wr) begin
               n_err++;
               $display("FAIL busy_start_cmd: got %h/%0d/%b, required %h/%0d/%b", s_addr, s_len, s_wr, ec.addr, ec.len, ec.wr);
            end
         end
         if (s_wbeat) begin
            n_cmp++;
            ed = (exp_data.size() != 0) ? exp_data.pop_front() : 16'hxxxx;
            if (s_wdata !== ed) begin
               n_err++;
               $display("FAIL busy_start_data: got %h, required %h", s_wdata, ed);
            end
            beats++;
            bus.client_wdata = 16'hB000 + 16'(beats);
         end
         if (s_done) done_seen = 1;
      end
      bus.client_wvalid = 1'b0;
      n_cmp++;
      if (!done_seen || beats !== 4 || exp_cmd.size() !== 0) begin
         n_err++;
         $display("FAIL busy_start_complete: got done %b beats %0d cmds_left %0d, required 1 4 0", done_seen, beats, exp_cmd.size());
      end
      cyc();
      n_cmp++;
      if (s_busy !== 1'b0 || s_wr !== 1'b1 || s_cmd_raw !== 1'b0) begin
         n_err++;
         $display("FAIL busy_start_after: got busy %b dir %b cmd %b, required 0 1 0", s_busy, s_wr, s_cmd_raw);
      end
   endtask

   task automatic test_reset_mid();
      int beats = 0;
      bit done_seen = 0;
      bus.client_wvalid = 1'b1;
      bus.client_wdata  = 16'hC000;
      do_start(16'h0600, 24'd40, 1'b1);
      for (int k = 0; k < 100 && beats < 10; k++) begin
         cyc();
         if (s_wbeat) begin
            beats++;
            bus.client_wdata = 16'hC000 + 16'(beats);
         end
      end
      reset = 1'b1;
      bus.client_wvalid = 1'b0;
      cyc();
      reset = 1'b0;
      cyc();
      n_cmp++;
      if ({s_busy, s_done, s_cmd_raw, s_mwrite, s_mread, s_wready, s_rvalid, s_burst, s_wr} !== 9'b0 ||
          s_addr !== 16'h0 || s_len !== 11'h0 || s_wdata !== 16'h0) begin
         n_err++;
         $display("FAIL reset_mid: got ctrl %b addr %h len %0d wdata %h, required all 0",
                  {s_busy, s_done, s_cmd_raw, s_mwrite, s_mread, s_wready, s_rvalid, s_burst, s_wr}, s_addr, s_len, s_wdata);
      end
      beats = 0;
      exp_cmd.delete(); exp_data.delete();
      exp_cmd.push_back('{16'h0800, 11'd4, 1'b1});
      for (int i = 0; i < 4; i++) exp_data.push_back(16'hD000 + 16'(i));
      bus.client_wvalid = 1'b1;
      bus.client_wdata  = 16'hD000;
      do_start(16'h0800, 24'd4, 1'b1);
      for (int k = 0; k < 50 && !done_seen; k++) begin
         cyc();
         if (s_cmd) begin
            n_cmp++;
            ec = (exp_cmd.size() != 0) ? exp_cmd.pop_front() : '{16'hxxxx, 11'hxxx, 1'bx};
            if (s_addr !== ec.addr || s_len !== ec.len || s_wr !== ec.wr) begin
               n_err++;
               $display("FAIL post_reset_cmd: got %h/%0d/%b, required %h/%0d/%b", s_addr, s_len, s_wr, ec.addr, ec.len, ec.wr);
            end
         end
         if (s_wbeat) begin
            n_cmp++;
            ed = (exp_data.size() != 0) ? exp_data.pop_front() : 16'hxxxx;
            if (s_wdata !== ed) begin
               n_err++;
               $display("FAIL post_reset_data: got %h, required %h", s_wdata, ed);
            end
            beats++;
            bus.client_wdata = 16'hD000 + 16'(beats);
         end
         if (s_done) done_seen = 1;
      end
      bus.client_wvalid = 1'b0;
      n_cmp++;
      if (!done_seen || beats !== 4 || exp_cmd.size() !== 0) begin
         n_err++;
         $display("FAIL post_reset_complete: got done %b beats %0d cmds_left %0d, required 1 4 0", done_seen, beats, exp_cmd.size());
      end
      cyc();
   endtask

   initial begin
      bus.start           = 1'b0;
      bus.start_addr      = '0;
      bus.start_words     = '0;
      bus.start_write     = 1'b0;
      bus.client_wdata    = '0;
      bus.client_wvalid   = 1'b0;
      bus.client_rready   = 1'b0;
      bus.master_readdata = '0;
      bus.master_stall    = 1'b0;
      test_reset();
      test_write_multi();
      test_read_single();
      test_stall_cmd();
      test_credit_cap();
      test_edge_starts();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of run, required completion before 200000 time units");
      $fatal(1, "watchdog expired");
   end
endmodule
